// File: rtl/aer_event_rx.sv
// aer_event_rx: captures one-hot AER grant pairs as timestamped events in a first-word fall-through FIFO
module aer_event_rx #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [ROWS-1:0]         x_gnt_i,
  input  logic [COLS-1:0]         y_gnt_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [$clog2(ROWS)-1:0] evt_row_o,
  output logic [$clog2(COLS)-1:0] evt_col_o,
  output logic [TS_W-1:0]         evt_ts_o,
  output logic [7:0]              drop_cnt_o,
  output logic                    proto_err_o
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = RW + CW + TS_W;
  logic [TS_W-1:0] ts;
  logic            prev_v;
  logic [ROWS-1:0] prev_x;
  logic [COLS-1:0] prev_y;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wp, rp;
  logic [AW:0]     cnt;
  logic            x_oh, y_oh, grant, err, new_evt, full, pop, push, drop;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  assign x_oh        = x_gnt_i != '0 && (x_gnt_i & (x_gnt_i - ROWS'(1))) == '0;
  assign y_oh        = y_gnt_i != '0 && (y_gnt_i & (y_gnt_i - COLS'(1))) == '0;
  assign grant       = x_oh && y_oh;
  assign err         = (x_gnt_i != '0 && !x_oh) || (y_gnt_i != '0 && !y_oh);
  assign full        = cnt == (AW+1)'(DEPTH);
  assign evt_valid_o = cnt != '0;
  assign pop         = evt_valid_o && evt_ready_i;
  assign new_evt     = !reset_i && enable_i && grant && (!prev_v || x_gnt_i != prev_x || y_gnt_i != prev_y);
  assign push        = new_evt && (!full || pop);
  assign drop        = new_evt && full && !pop;
  assign {evt_row_o, evt_col_o, evt_ts_o} = evt_valid_o ? mem[rp] : '0;
  always_comb begin
    row = '0;
    col = '0;
    for (int i = 0; i < ROWS; i++) row = x_gnt_i[i] ? row | RW'(i) : row;
    for (int i = 0; i < COLS; i++) col = y_gnt_i[i] ? col | CW'(i) : col;
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= {row, col, ts};
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts          <= '0;
      prev_v      <= 1'b0;
      prev_x      <= '0;
      prev_y      <= '0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      drop_cnt_o  <= '0;
      proto_err_o <= 1'b0;
    end else begin
      ts          <= enable_i ? ts + TS_W'(1) : ts;
      prev_v      <= grant;
      prev_x      <= x_gnt_i;
      prev_y      <= y_gnt_i;
      wp          <= push ? wp + AW'(1) : wp;
      rp          <= pop ? rp + AW'(1) : rp;
      cnt         <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      drop_cnt_o  <= (drop && drop_cnt_o != 8'hff) ? drop_cnt_o + 8'd1 : drop_cnt_o;
      proto_err_o <= proto_err_o | err;
    end
  end
endmodule

// File: tb/tb_aer_event_rx.sv
// tb_aer_event_rx: directed checks of event capture, FIFO flow control, errors, timestamp wrap and reset
module tb_aer_event_rx;
  logic       clk_i = 1'b0;
  logic       reset_i, enable_i, evt_ready_i;
  logic [7:0] x_gnt_i, y_gnt_i;
  logic       evt_valid_o, proto_err_o;
  logic [2:0] evt_row_o, evt_col_o;
  logic [3:0] evt_ts_o;
  logic [7:0] drop_cnt_o;
  int         n_vec = 0, n_err = 0;
  int         ts_m = 0, e_ts = 0, e_ts2 = 0;
  int         rts [6];
  aer_event_rx #(.ROWS(8), .COLS(8), .TS_W(4), .DEPTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .x_gnt_i(x_gnt_i), .y_gnt_i(y_gnt_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_row_o(evt_row_o), .evt_col_o(evt_col_o), .evt_ts_o(evt_ts_o),
    .drop_cnt_o(drop_cnt_o), .proto_err_o(proto_err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    ts_m = reset_i ? 0 : (enable_i ? (ts_m + 1) % 16 : ts_m);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  initial begin
    reset_i = 1; enable_i = 0; evt_ready_i = 0; x_gnt_i = 0; y_gnt_i = 0;
    tick; tick;
    reset_i = 0;
    chk("rst_valid", 32'(evt_valid_o), 0);
    chk("rst_row", 32'(evt_row_o), 0);
    chk("rst_col", 32'(evt_col_o), 0);
    chk("rst_ts", 32'(evt_ts_o), 0);
    chk("rst_drop", 32'(drop_cnt_o), 0);
    chk("rst_err", 32'(proto_err_o), 0);
    enable_i = 1;
    repeat (5) tick;
    x_gnt_i = 8'b0000_0100; y_gnt_i = 8'b0010_0000;
    tick;
    x_gnt_i = 0; y_gnt_i = 0;
    chk("single_valid", 32'(evt_valid_o), 1);
    chk("single_row", 32'(evt_row_o), 2);
    chk("single_col", 32'(evt_col_o), 5);
    chk("single_ts", 32'(evt_ts_o), 5);
    evt_ready_i = 1; tick; evt_ready_i = 0;
    chk("single_popped", 32'(evt_valid_o), 0);
    e_ts = ts_m;
    x_gnt_i = 8'h01; y_gnt_i = 8'h01;
    repeat (4) tick;
    x_gnt_i = 0; y_gnt_i = 0;
    chk("held_valid", 32'(evt_valid_o), 1);
    chk("held_ts", 32'(evt_ts_o), 32'(e_ts));
    evt_ready_i = 1; tick; evt_ready_i = 0;
    chk("held_once", 32'(evt_valid_o), 0);
    for (int i = 0; i < 6; i++) begin
      rts[i] = ts_m;
      x_gnt_i = 8'(1 << i); y_gnt_i = 8'(8'h80 >> i);
      tick;
    end
    x_gnt_i = 0; y_gnt_i = 0;
    chk("ovf_drop", 32'(drop_cnt_o), 2);
    chk("ovf_valid", 32'(evt_valid_o), 1);
    evt_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_row", 32'(evt_row_o), 32'(k));
      chk("ovf_col", 32'(evt_col_o), 32'(7 - k));
      chk("ovf_ts", 32'(evt_ts_o), 32'(rts[k]));
      tick;
    end
    chk("ovf_drained", 32'(evt_valid_o), 0);
    evt_ready_i = 0;
    x_gnt_i = 8'b0001_0001; y_gnt_i = 8'h01;
    tick;
    x_gnt_i = 0; y_gnt_i = 0;
    chk("perr_set", 32'(proto_err_o), 1);
    chk("perr_nopush", 32'(evt_valid_o), 0);
    repeat (3) tick;
    chk("perr_sticky", 32'(proto_err_o), 1);
    e_ts = ts_m;
    x_gnt_i = 8'h02; y_gnt_i = 8'h02; tick;
    x_gnt_i = 8'h03; tick;
    e_ts2 = ts_m;
    x_gnt_i = 8'h02; tick;
    x_gnt_i = 0; y_gnt_i = 0;
    chk("perr_a_ts", 32'(evt_ts_o), 32'(e_ts));
    evt_ready_i = 1; tick;
    chk("perr_b_valid", 32'(evt_valid_o), 1);
    chk("perr_b_row", 32'(evt_row_o), 1);
    chk("perr_b_ts", 32'(evt_ts_o), 32'(e_ts2));
    tick;
    chk("perr_drained", 32'(evt_valid_o), 0);
    evt_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      x_gnt_i = 8'(1 << i); y_gnt_i = 8'h01;
      tick;
    end
    x_gnt_i = 8'h10; evt_ready_i = 1;
    tick;
    x_gnt_i = 0; y_gnt_i = 0; evt_ready_i = 0;
    chk("fullpp_drop", 32'(drop_cnt_o), 2);
    evt_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      chk("fullpp_row", 32'(evt_row_o), 32'(k + 1));
      tick;
    end
    chk("fullpp_drained", 32'(evt_valid_o), 0);
    evt_ready_i = 0;
    x_gnt_i = 8'h40; y_gnt_i = 8'h40; tick;
    x_gnt_i = 8'h80; y_gnt_i = 8'h80; evt_ready_i = 1; tick;
    x_gnt_i = 0; y_gnt_i = 0; evt_ready_i = 0;
    chk("onepp_valid", 32'(evt_valid_o), 1);
    chk("onepp_row", 32'(evt_row_o), 7);
    chk("onepp_col", 32'(evt_col_o), 7);
    evt_ready_i = 1; tick; evt_ready_i = 0;
    chk("onepp_drained", 32'(evt_valid_o), 0);
    repeat ((15 - ts_m + 16) % 16) tick;
    x_gnt_i = 8'h01; y_gnt_i = 8'h02; tick;
    x_gnt_i = 8'h04; y_gnt_i = 8'h08; tick;
    x_gnt_i = 0; y_gnt_i = 0;
    chk("wrap_ts15", 32'(evt_ts_o), 15);
    evt_ready_i = 1; tick; evt_ready_i = 0;
    chk("wrap_ts0", 32'(evt_ts_o), 0);
    chk("wrap_row", 32'(evt_row_o), 2);
    chk("wrap_col", 32'(evt_col_o), 3);
    reset_i = 1; x_gnt_i = 8'h10; y_gnt_i = 8'h10;
    tick;
    reset_i = 0; x_gnt_i = 0; y_gnt_i = 0;
    chk("mrst_valid", 32'(evt_valid_o), 0);
    chk("mrst_row", 32'(evt_row_o), 0);
    chk("mrst_col", 32'(evt_col_o), 0);
    chk("mrst_ts", 32'(evt_ts_o), 0);
    chk("mrst_drop", 32'(drop_cnt_o), 0);
    chk("mrst_err", 32'(proto_err_o), 0);
    tick;
    chk("mrst_nocapture", 32'(evt_valid_o), 0);
    e_ts = ts_m;
    x_gnt_i = 8'h01; y_gnt_i = 8'h01; tick;
    x_gnt_i = 0; y_gnt_i = 0;
    chk("post_rst_valid", 32'(evt_valid_o), 1);
    chk("post_rst_ts", 32'(evt_ts_o), 32'(e_ts));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aer_event_rx.md
AER_EVENT_RX -- requirements
Module: aer_event_rx

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of pixel rows (one-hot row grant width).
REQ-002 SHALL have parameter COLS, default 8, number of pixel columns (one-hot column grant width).
REQ-003 SHALL have parameter TS_W, default 16, timestamp width.
REQ-004 SHALL have parameter DEPTH, default 4, event FIFO entries (power of 2, >=2).
REQ-005 SHALL have port clk_i, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable_i, input, 1, capture and timestamp enable.
REQ-008 SHALL have port x_gnt_i, input, ROWS, one-hot row grant from the arbiter.
REQ-009 SHALL have port y_gnt_i, input, COLS, one-hot column grant from the arbiter.
REQ-010 SHALL have port evt_valid_o, output, 1, FIFO head holds an event.
REQ-011 SHALL have port evt_ready_i, input, 1, consumer accepts the head event.
REQ-012 SHALL have port evt_row_o, output, $clog2(ROWS), binary row address of the head event.
REQ-013 SHALL have port evt_col_o, output, $clog2(COLS), binary column address of the head event.
REQ-014 SHALL have port evt_ts_o, output, TS_W, timestamp of the head event.
REQ-015 SHALL have port drop_cnt_o, output, 8, saturating count of events dropped on a full FIFO.
REQ-016 SHALL have port proto_err_o, output, 1, sticky flag for a non-one-hot grant.

Function
REQ-017 SHALL run a free-running timestamp counter that increments by 1 in each cycle with enable_i=1, holds otherwise, and wraps from 2^TS_W-1 to 0.
REQ-018 SHALL classify a cycle as a grant cycle when x_gnt_i and y_gnt_i are both exactly one-hot.
REQ-019 SHALL detect a new event in a grant cycle with enable_i=1 when the {x_gnt_i,y_gnt_i} pair differs from the previous cycle's pair, or when the previous cycle was not a grant cycle.
REQ-020 SHALL NOT treat a grant pair held for several cycles as more than one event.
REQ-021 SHALL encode a new event as row = index of the set x_gnt_i bit, col = index of the set y_gnt_i bit, ts = the timestamp counter value in the same cycle.
REQ-022 SHALL set proto_err_o the cycle after any cycle where either grant is nonzero and not one-hot, and SHALL NOT capture an event in that cycle.
REQ-023 SHALL hold proto_err_o set until reset.
REQ-024 SHALL leave the previous-pair register invalid after an error cycle, so that the next one-hot pair is treated as a new event.
REQ-025 SHALL push each new event into a DEPTH-entry FIFO with first-word fall-through.
REQ-026 SHALL drive evt_valid_o, evt_row_o, evt_col_o and evt_ts_o from registered FIFO state, so that an event detected in cycle N appears at the outputs in cycle N+1 when the FIFO was empty.
REQ-027 SHALL complete a handshake in any cycle with evt_valid_o=1 and evt_ready_i=1, and SHALL then pop the head entry.
REQ-028 SHALL hold the head data stable while evt_valid_o=1 and evt_ready_i=0.
REQ-029 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-030 SHALL, when an event arrives with the FIFO full and no pop that cycle, drop the event and increment drop_cnt_o, saturating at 255.
REQ-031 SHALL, on a simultaneous push and pop with one entry stored, present the new event at the head in the next cycle, keeping evt_valid_o=1.
REQ-032 SHALL wrap the FIFO read and write pointers modulo DEPTH, and SHALL hold an occupancy count in the range 0..DEPTH.
REQ-033 SHALL ignore evt_ready_i while evt_valid_o=0.

Reset
REQ-034 SHALL, while reset_i=1 at a clock edge, set the timestamp to 0, occupancy to 0, evt_valid_o=0, evt_row_o/evt_col_o/evt_ts_o=0, drop_cnt_o=0 and proto_err_o=0, and SHALL clear the previous-pair register to invalid.
REQ-035 SHALL discard FIFO contents when reset is asserted mid-operation, and SHALL capture no event in a reset cycle.

Verification
REQ-036 SHALL verify single event: enable_i=1, x_gnt_i=8'b0000_0100, y_gnt_i=8'b0010_0000 for 1 cycle at ts=5 -> next cycle evt_valid_o=1, row=2, col=5, ts=5.
REQ-037 SHALL verify held grant: the same pair held for 4 cycles -> exactly one event is pushed.
REQ-038 SHALL verify overflow: 6 distinct events with evt_ready_i=0 and DEPTH=4 -> 4 events are stored and drop_cnt_o=2; then evt_ready_i=1 -> the 4 events drain in order, after which evt_valid_o=0.
REQ-039 SHALL verify protocol error: x_gnt_i=8'b0001_0001 with a valid y_gnt_i -> proto_err_o=1 from the next cycle, no push, and the flag stays set.
REQ-040 SHALL verify full FIFO with simultaneous push and pop: full FIFO, evt_ready_i=1 and a new event in the same cycle -> the event is accepted, drop_cnt_o is unchanged, and occupancy stays 4.
REQ-041 SHALL verify timestamp wrap and reset: TS_W=4, event at ts=15 then an event 1 cycle later -> ts=0; reset_i asserted mid-stream -> all outputs reach their reset values on the next edge.
